// File: rtl/sipo_pkg.sv
// Shared types and sizing helpers for the serial-in, parallel-out receiver.
package sipo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Counter must be able to represent WIDTH itself, hence clog2 of WIDTH+1.
  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Shifter, bit counter and word-framing FSM; emits a completion strobe plus the assembled word.
//   state | meaning
//   IDLE  | bit_count = 0, no partial word held
//   SHIFT | 0 < bit_count < WIDTH, partial word in the shifter
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b0,
  parameter int CW        = count_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             serial_in,
  input  logic             in_valid,
  output logic [CW-1:0]    bit_count,
  output logic             complete,
  output logic [WIDTH-1:0] word
);

  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state, state_next;
  logic [WIDTH-1:0] shifter, shifter_next, shifted;
  logic [CW-1:0]    count_next;

  assign shifted = MSB_FIRST ? {shifter[WIDTH-2:0], serial_in}
                             : {serial_in, shifter[WIDTH-1:1]};

  // Completion word includes the bit being sampled on this edge.
  assign word = shifted;

  always_comb begin
    state_next   = state;
    count_next   = bit_count;
    shifter_next = shifter;
    complete     = 1'b0;
    if (in_valid) begin
      shifter_next = shifted;
      if (bit_count == LAST_BIT) begin
        count_next = '0;
        state_next = IDLE;
        complete   = 1'b1;
      end else begin
        count_next = bit_count + CW'(1);
        state_next = SHIFT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_count <= '0;
      shifter   <= '0;
    end else if (flush) begin
      state     <= IDLE;
      bit_count <= '0;
      shifter   <= '0;
    end else begin
      state     <= state_next;
      bit_count <= count_next;
      shifter   <= shifter_next;
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in, parallel-out receiver: shift core plus holding register, valid/ready output and sticky overrun.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         serial_in,
  input  logic                         in_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             parallel_out,
  output logic                         out_valid,
  output logic                         busy,
  output logic [count_width(WIDTH)-1:0] bit_count,
  output logic                         overrun
);

  localparam int CW = count_width(WIDTH);

  logic             complete;
  logic [WIDTH-1:0] word;

  sipo_shift_core #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST),
    .CW       (CW)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .serial_in(serial_in),
    .in_valid (in_valid),
    .bit_count(bit_count),
    .complete (complete),
    .word     (word)
  );

  assign busy = (bit_count != '0);

  // A word completing in the same edge the held word is consumed is not an overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parallel_out <= '0;
      out_valid    <= 1'b0;
      overrun      <= 1'b0;
    end else if (flush) begin
      parallel_out <= '0;
      out_valid    <= 1'b0;
      overrun      <= 1'b0;
    end else if (complete) begin
      if (!out_valid || out_ready) begin
        parallel_out <= word;
        out_valid    <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: LSB-first and MSB-first instances share one stimulus stream.
module tb_sipo_deserializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       serial_in = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;

  logic [3:0] a_po, b_po;
  logic       a_ov, b_ov, a_busy, b_busy, a_orun, b_orun;
  logic [2:0] a_bc, b_bc;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .serial_in(serial_in), .in_valid(in_valid),
    .out_ready(out_ready), .parallel_out(a_po), .out_valid(a_ov), .busy(a_busy),
    .bit_count(a_bc), .overrun(a_orun)
  );

  sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .serial_in(serial_in), .in_valid(in_valid),
    .out_ready(out_ready), .parallel_out(b_po), .out_valid(b_ov), .busy(b_busy),
    .bit_count(b_bc), .overrun(b_orun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive inputs at a falling edge, take one rising edge, return at the next falling edge.
  task automatic step(input logic sv, input logic iv, input logic rdy);
    serial_in = sv;
    in_valid  = iv;
    out_ready = rdy;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    flush = 1'b0;
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_po", a_po, 4'h0);
    chk("rst_ov", a_ov, 1'b0);
    chk("rst_bc", a_bc, 3'd0);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_orun", a_orun, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Basic LSB-first word 0,1,0,1 -> 1010
    step(1'b0, 1'b1, 1'b1);
    chk("t1_bc1", a_bc, 3'd1); chk("t1_busy1", a_busy, 1'b1); chk("t1_ov1", a_ov, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("t1_bc2", a_bc, 3'd2); chk("t1_busy2", a_busy, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    chk("t1_bc3", a_bc, 3'd3); chk("t1_busy3", a_busy, 1'b1); chk("t1_ov3", a_ov, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("t1_bc0", a_bc, 3'd0); chk("t1_busy0", a_busy, 1'b0);
    chk("t1_ov", a_ov, 1'b1); chk("t1_po", a_po, 4'b1010);
    step(1'b0, 1'b0, 1'b1);
    chk("t1_ov_drop", a_ov, 1'b0); chk("t1_po_hold", a_po, 4'b1010);

    // MSB-first with a two-cycle gap: 1,1,_,_,0,1 -> 1101
    do_flush();
    chk("t2_flush_bc", b_bc, 3'd0);
    step(1'b1, 1'b1, 1'b1); chk("t2_bc1", b_bc, 3'd1);
    step(1'b1, 1'b1, 1'b1); chk("t2_bc2", b_bc, 3'd2);
    step(1'b0, 1'b0, 1'b1); chk("t2_gap1", b_bc, 3'd2);
    step(1'b1, 1'b0, 1'b1); chk("t2_gap2", b_bc, 3'd2); chk("t2_busy", b_busy, 1'b1);
    step(1'b0, 1'b1, 1'b1); chk("t2_bc3", b_bc, 3'd3);
    step(1'b1, 1'b1, 1'b1);
    chk("t2_ov", b_ov, 1'b1); chk("t2_po", b_po, 4'b1101); chk("t2_bc0", b_bc, 3'd0);

    // Back-pressure and overrun on the LSB-first instance
    do_flush();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
    chk("t3_w1_po", a_po, 4'b1111); chk("t3_w1_ov", a_ov, 1'b1); chk("t3_w1_orun", a_orun, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
    chk("t3_w2_po", a_po, 4'b1111); chk("t3_w2_ov", a_ov, 1'b1); chk("t3_w2_orun", a_orun, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("t3_cons_ov", a_ov, 1'b0); chk("t3_cons_orun", a_orun, 1'b1);
    do_flush();
    chk("t3_flush_orun", a_orun, 1'b0); chk("t3_flush_po", a_po, 4'h0);

    // Full-rate streaming 1010, 0110, 1111 (LSB first)
    begin
      logic [3:0] words [3];
      logic [3:0] w;
      words[0] = 4'b1010; words[1] = 4'b0110; words[2] = 4'b1111;
      for (int k = 0; k < 3; k++) begin
        w = words[k];
        for (int i = 0; i < 4; i++) begin
          step(w[i], 1'b1, 1'b1);
          if (i == 0 && k != 0) chk("t4_drop", a_ov, 1'b0);
        end
        chk("t4_ov", a_ov, 1'b1); chk("t4_po", a_po, w); chk("t4_orun", a_orun, 1'b0);
      end
    end
    step(1'b0, 1'b0, 1'b1);
    chk("t4_end_ov", a_ov, 1'b0);

    // Consume and complete on the same edge
    do_flush();
    begin
      logic [3:0] w;
      w = 4'b0011;
      for (int i = 0; i < 4; i++) step(w[i], 1'b1, 1'b0);
      chk("t5_hold_po", a_po, 4'b0011); chk("t5_hold_ov", a_ov, 1'b1);
      w = 4'b1100;
      for (int i = 0; i < 3; i++) step(w[i], 1'b1, 1'b0);
      step(w[3], 1'b1, 1'b1);
    end
    chk("t5_ov", a_ov, 1'b1); chk("t5_po", a_po, 4'b1100); chk("t5_orun", a_orun, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("t5_ov_keep", a_ov, 1'b1);

    // Async reset mid-word
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("t6_bc2", a_bc, 3'd2);
    #2 rst = 1'b1;
    #1;
    chk("t6_bc", a_bc, 3'd0); chk("t6_busy", a_busy, 1'b0);
    chk("t6_ov", a_ov, 1'b0); chk("t6_po", a_po, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    begin
      logic [3:0] w;
      w = 4'b1001;
      for (int i = 0; i < 4; i++) step(w[i], 1'b1, 1'b1);
    end
    chk("t6_po_new", a_po, 4'b1001); chk("t6_ov_new", a_ov, 1'b1); chk("t6_orun", a_orun, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
- Serial-in, parallel-out receiver. It is the far end of the team's PISO right-shift transmitter: it takes one bit per qualified clock and reassembles WIDTH-bit words.
- A completed word is presented on a registered output with a valid/ready handshake.
- A holding register lets the next word shift in while the previous word waits for ready.
- Overrun is detected and flagged.

Parameters:
- WIDTH, 4, word length in bits (≥2).
- MSB_FIRST, 0. When 0 the first received bit lands in parallel_out[0], matching the right-shift transmitter's LSB-first order. When 1 the first bit lands in parallel_out[WIDTH-1].

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of shifter, counter, holding register and overrun flag.
- serial_in  in  1  serial data bit.
- in_valid  in  1  serial_in is sampled on this rising edge.
- out_ready  in  1  downstream accepts parallel_out this edge.
- parallel_out  out  WIDTH  assembled word (holding register).
- out_valid  out  1  parallel_out holds an unconsumed word.
- busy  out  1  a partial word is in the shifter (bit count ≠ 0).
- bit_count  out  $clog2(WIDTH+1)  bits received in the current word.
- overrun  out  1  sticky flag: a completed word was dropped.

Behaviour:
- Reset (async, rst=1): shifter=0, bit_count=0, parallel_out=0, out_valid=0, busy=0, overrun=0, state=IDLE. Reset takes effect immediately, mid-word included. The partial word is discarded.
- Priority at each edge: rst > flush > normal operation.
- flush=1: same values as reset, applied at the edge. in_valid and out_ready are ignored that cycle.
- States:
  - IDLE (bit_count=0).
  - SHIFT (0<bit_count<WIDTH).
  - IDLE→SHIFT on the first qualified bit.
  - SHIFT→SHIFT while bit_count+1<WIDTH.
  - SHIFT→IDLE on the WIDTH-th bit.
- Sampling: only when in_valid=1. When in_valid=0 the shifter and count hold, and gaps of any length are allowed.
  - MSB_FIRST=0: shifter shifts right, new bit enters at [WIDTH-1].
  - MSB_FIRST=1: shifter shifts left, new bit enters at [0].
- Completion on the edge that samples the WIDTH-th bit:
  - The assembled word (shifter plus the current bit) is written to parallel_out.
  - out_valid=1 from the next cycle.
  - bit_count returns to 0 on that same edge.
- Latency: parallel_out/out_valid are visible one clock after the last bit's edge.
- Handshake: a word is consumed on an edge with out_valid=1 and out_ready=1, and out_valid then drops to 0. out_ready while out_valid=0 has no effect. parallel_out holds its value after consumption.
- Simultaneous consume and completion in the same edge: the new word is loaded and out_valid stays 1. This is not an overrun, so back-to-back words at full rate are lossless.
- Overrun: completion while out_valid=1 and out_ready=0.
  - The held word is kept.
  - The new word is discarded.
  - overrun=1 and stays 1 until rst or flush.
  - The shifter continues with the next word normally.
- busy = (bit_count≠0). It is combinational from the register.
- No combinational path from any input to any output.

Decomposition:
- Package sipo_pkg:
  - state enum {IDLE, SHIFT}.
  - Count-width helper function (clog2 of WIDTH+1).
  - Default WIDTH constant.
- Sub-module sipo_shift_core (shifter, bit counter, state machine, completion pulse plus word). The top adds the holding register, handshake and overrun logic.

Test Plan:
- Reset and basic word: rst 1→0, WIDTH=4, MSB_FIRST=0, out_ready=1. Send bits 0,1,0,1 on four consecutive edges. Required: parallel_out=4'b1010 and out_valid=1 for exactly one cycle after the 4th edge, bit_count sequence 1,2,3,0, busy high for 3 cycles.
- Order and gaps: MSB_FIRST=1, send 1,1,0,1 with in_valid low for 2 cycles between bits 2 and 3. Required: parallel_out=4'b1101, and bit_count holds at 2 during the gap.
- Back-pressure and overrun: out_ready=0. Send 4'b1111 (all ones), then 4'b0000. Required: after the second word parallel_out still 4'b1111, out_valid=1, overrun=1. Raise out_ready: out_valid→0 while overrun stays 1. Pulse flush: overrun→0.
- Full-rate streaming: out_ready=1, send 4'b1010, 4'b0110 and 4'b1111 continuously (12 edges). Required: three words output in order, out_valid high on consecutive completion cycles, overrun never set.
- Simultaneous consume/complete: hold word 4'b0011 with out_ready=0. Raise out_ready on the same edge as the last bit of 4'b1100. Required: out_valid stays 1, parallel_out=4'b1100, overrun=0.
- Async reset mid-word: after 2 bits, assert rst between clock edges. Required: bit_count=0, busy=0, out_valid=0 and parallel_out=0 immediately, without a clock edge. After release, the next 4 bits form a clean word.
